// File: rtl/uart_rx.sv
// 8N1 UART receiver clocked at 16x the baud rate. Each bit is recovered by a
// 2-of-3 majority vote over the samples at counts 7, 8 and 9 of the bit.
// Good frames update o_data and pulse o_rx_done. A low stop bit pulses
// o_frame_err and leaves o_data unchanged.
module uart_rx (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic       i_rx,
  output logic [7:0] o_data,
  output logic       o_rx_done,
  output logic       o_frame_err,
  output logic       o_busy
);

  typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;

  state_e     state_q;
  logic       rx_s1_q;
  logic       rx_s2_q;
  logic       rx_prev_q;
  logic [3:0] cnt16_q;
  logic [2:0] bit_cnt_q;
  logic [7:0] shift_q;
  logic [2:0] samp_q;
  logic [7:0] data_q;
  logic       done_q;
  logic       err_q;
  logic       busy_q;

  logic       start_det;
  logic       bit_maj;
  logic       stop_maj;

  // A start is a 1->0 transition on the synchronised line, so a line held low
  // (break) never restarts the receiver.
  assign start_det = ~rx_s2_q & rx_prev_q;

  // Majority of the three stored mid-bit samples, used at the end of a bit.
  assign bit_maj = (samp_q[0] & samp_q[1]) | (samp_q[0] & samp_q[2]) |
                   (samp_q[1] & samp_q[2]);

  // The stop bit is decided at count 9, so the third sample is the live input.
  assign stop_maj = (samp_q[0] & samp_q[1]) | (samp_q[0] & rx_s2_q) |
                    (samp_q[1] & rx_s2_q);

  // Two-flop synchroniser plus one cycle of edge history; reset to idle-high.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      rx_s1_q   <= 1'b1;
      rx_s2_q   <= 1'b1;
      rx_prev_q <= 1'b1;
    end else begin
      rx_s1_q   <= i_rx;
      rx_s2_q   <= rx_s1_q;
      rx_prev_q <= rx_s2_q;
    end
  end

  // Receive FSM with counters, sample capture and registered outputs.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q   <= StIdle;
      cnt16_q   <= 4'd0;
      bit_cnt_q <= 3'd0;
      shift_q   <= 8'h00;
      samp_q    <= 3'b111;
      data_q    <= 8'h00;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;

      if (state_q != StIdle) begin
        case (cnt16_q)
          4'd7:    samp_q[0] <= rx_s2_q;
          4'd8:    samp_q[1] <= rx_s2_q;
          4'd9:    samp_q[2] <= rx_s2_q;
          default: ;
        endcase
      end

      unique case (state_q)
        StIdle: begin
          cnt16_q   <= 4'd0;
          bit_cnt_q <= 3'd0;
          if (start_det) begin
            state_q <= StStart;
            busy_q  <= 1'b1;
          end
        end

        StStart: begin
          cnt16_q <= cnt16_q + 4'd1;
          if (cnt16_q == 4'd15) begin
            if (!bit_maj) begin
              state_q <= StData;
            end else begin
              // Start bit did not hold low at mid-bit: treat as a glitch.
              state_q <= StIdle;
              busy_q  <= 1'b0;
            end
          end
        end

        StData: begin
          cnt16_q <= cnt16_q + 4'd1;
          if (cnt16_q == 4'd15) begin
            // LSB arrives first, so shifting right leaves bit 0 first-received.
            shift_q <= {bit_maj, shift_q[7:1]};
            if (bit_cnt_q == 3'd7) begin
              state_q   <= StStop;
              bit_cnt_q <= 3'd0;
            end else begin
              bit_cnt_q <= bit_cnt_q + 3'd1;
            end
          end
        end

        StStop: begin
          // Leave early at count 9 so a start bit directly after the stop bit
          // still finds the FSM idle once the synchroniser delay is absorbed.
          if (cnt16_q == 4'd9) begin
            cnt16_q <= 4'd0;
            state_q <= StIdle;
            busy_q  <= 1'b0;
            if (stop_maj) begin
              data_q <= shift_q;
              done_q <= 1'b1;
            end else begin
              err_q <= 1'b1;
            end
          end else begin
            cnt16_q <= cnt16_q + 4'd1;
          end
        end

        default: state_q <= StIdle;
      endcase
    end
  end

  assign o_data      = data_q;
  assign o_rx_done   = done_q;
  assign o_frame_err = err_q;
  assign o_busy      = busy_q;

endmodule
